// File: rtl/clock_tick_generator.sv
// Multi-channel prescaler: per-channel runtime-loadable divisors, one-cycle clock-enable
// ticks and 50 % square waves, with optional cascading of channel i onto channel i-1 wraps.
module clock_tick_generator #(
   parameter int unsigned WIDTH       = 26,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned DEFAULT_DIV = 50000000,
   parameter int unsigned CASCADE     = 0
) (
   input  logic                      clock_in,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      load,
   input  logic [CHANNELS*WIDTH-1:0] div_value,
   output logic [CHANNELS-1:0]       ticks,
   output logic [CHANNELS-1:0]       squares
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0]    cnt   [CHANNELS];
   logic [WIDTH-1:0]    div_q [CHANNELS];
   logic [CHANNELS-1:0] adv;
   logic [CHANNELS-1:0] wrap;

   // Terminal count; divisors 0 and 1 both wrap on every advance.
   function automatic logic [WIDTH-1:0] last_of(input logic [WIDTH-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   // The cascade chain is carried in a local so every stage's wrap settles in the same cycle.
   always_comb begin
      logic carry;
      logic a;
      logic w;
      adv   = '0;
      wrap  = '0;
      carry = enable;
      a     = 1'b0;
      w     = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         a       = (CASCADE != 0) ? carry : enable;
         w       = a & (cnt[i] == last_of(div_q[i]));
         adv[i]  = a;
         wrap[i] = w;
         carry   = w;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i]   <= '0;
            div_q[i] <= DEF_DIV;
         end
         ticks   <= '0;
         squares <= '0;
      end else if (load) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i]   <= '0;
            div_q[i] <= div_value[i*WIDTH +: WIDTH];
         end
         ticks   <= '0;
         squares <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (wrap[i]) begin
               cnt[i]     <= '0;
               ticks[i]   <= 1'b1;
               squares[i] <= ~squares[i];
            end else begin
               ticks[i] <= 1'b0;
               if (adv[i]) cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_bound
      a_cnt_bound: assert property (@(posedge clock_in) disable iff (reset)
                                    cnt[g] <= last_of(div_q[g]));
   end

endmodule

// File: tb/tb_clock_tick_generator.sv
// Bench for clock_tick_generator: a plain non-cascaded 2-channel instance and a 4-bit
// cascaded 2-channel instance, checked against tables, directed sequences and an arithmetic model.
module tb_clock_tick_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, en_a = 1'b0, ld_a = 1'b0;
   logic [15:0] div_a = '0;
   logic [1:0]  ticks_a, squares_a;
   logic        rst_c = 1'b1, en_c = 1'b0, ld_c = 1'b0;
   logic [7:0]  div_c = '0;
   logic [1:0]  ticks_c, squares_c;

   clock_tick_generator #(.WIDTH(8), .CHANNELS(2), .DEFAULT_DIV(4), .CASCADE(0)) u_a (
      .clock_in(clk), .reset(rst_a), .enable(en_a), .load(ld_a),
      .div_value(div_a), .ticks(ticks_a), .squares(squares_a));

   clock_tick_generator #(.WIDTH(4), .CHANNELS(2), .DEFAULT_DIV(15), .CASCADE(1)) u_c (
      .clock_in(clk), .reset(rst_c), .enable(en_c), .load(ld_c),
      .div_value(div_c), .ticks(ticks_c), .squares(squares_c));

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference model: count enabled cycles since the last restart; a channel ticks whenever
   // that count reaches a multiple of its period, and its square is the parity of the quotient.
   function automatic longint eff(input longint v);
      return (v == 0) ? 1 : v;
   endfunction

   longint     na, nc;
   longint     da [2];
   longint     dc [2];
   logic [1:0] ea_t, ea_s, ec_t, ec_s;

   always @(posedge clk) begin
      if (rst_a) begin
         na <= 0; da[0] <= 4; da[1] <= 4; ea_t <= '0; ea_s <= '0;
      end else if (ld_a) begin
         na <= 0; ea_t <= '0; ea_s <= '0;
         da[0] <= eff(longint'(div_a[7:0]));
         da[1] <= eff(longint'(div_a[15:8]));
      end else if (en_a) begin
         na <= na + 1;
         for (int i = 0; i < 2; i++) begin
            ea_t[i] <= ((na + 1) % da[i]) == 0;
            ea_s[i] <= ((na + 1) / da[i]) % 2 == 1;
         end
      end else begin
         ea_t <= '0;
      end
   end

   always @(posedge clk) begin
      if (rst_c) begin
         nc <= 0; dc[0] <= 15; dc[1] <= 15; ec_t <= '0; ec_s <= '0;
      end else if (ld_c) begin
         nc <= 0; ec_t <= '0; ec_s <= '0;
         dc[0] <= eff(longint'(div_c[3:0]));
         dc[1] <= eff(longint'(div_c[7:4]));
      end else if (en_c) begin
         nc <= nc + 1;
         ec_t[0] <= ((nc + 1) % dc[0]) == 0;
         ec_s[0] <= ((nc + 1) / dc[0]) % 2 == 1;
         ec_t[1] <= ((nc + 1) % (dc[0] * dc[1])) == 0;
         ec_s[1] <= ((nc + 1) / (dc[0] * dc[1])) % 2 == 1;
      end else begin
         ec_t <= '0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_a_ticks", ticks_a, ea_t);
         check("model_a_squares", squares_a, ea_s);
         check("model_c_ticks", ticks_c, ec_t);
         check("model_c_squares", squares_c, ec_s);
      end
   end

   typedef struct {
      logic       en;
      logic [1:0] t;
      logic [1:0] s;
   } vec_t;

   vec_t rst_tab   [12];
   vec_t pause_tab [8];

   task automatic load_a(input logic [15:0] v);
      @(negedge clk); ld_a = 1'b1; div_a = v;
      @(negedge clk); ld_a = 1'b0;
      check("load_a_clear_t", ticks_a, 2'b00);
      check("load_a_clear_s", squares_a, 2'b00);
   endtask

   task automatic load_c(input logic [7:0] v);
      @(negedge clk); ld_c = 1'b1; div_c = v;
      @(negedge clk); ld_c = 1'b0;
      check("load_c_clear_t", ticks_c, 2'b00);
   endtask

   initial begin
      int tick_cnt;
      logic [1:0] req;

      // Record k: enable for edge k, outputs expected in the cycle after it.
      rst_tab[0]  = '{1'b1, 2'b00, 2'b00};
      rst_tab[1]  = '{1'b1, 2'b00, 2'b00};
      rst_tab[2]  = '{1'b1, 2'b00, 2'b00};
      rst_tab[3]  = '{1'b1, 2'b11, 2'b11};
      rst_tab[4]  = '{1'b1, 2'b00, 2'b11};
      rst_tab[5]  = '{1'b1, 2'b00, 2'b11};
      rst_tab[6]  = '{1'b1, 2'b00, 2'b11};
      rst_tab[7]  = '{1'b1, 2'b11, 2'b00};
      rst_tab[8]  = '{1'b1, 2'b00, 2'b00};
      rst_tab[9]  = '{1'b1, 2'b00, 2'b00};
      rst_tab[10] = '{1'b1, 2'b00, 2'b00};
      rst_tab[11] = '{1'b1, 2'b11, 2'b11};
      pause_tab[0] = '{1'b1, 2'b00, 2'b00};
      pause_tab[1] = '{1'b1, 2'b00, 2'b00};
      pause_tab[2] = '{1'b0, 2'b00, 2'b00};
      pause_tab[3] = '{1'b0, 2'b00, 2'b00};
      pause_tab[4] = '{1'b0, 2'b00, 2'b00};
      pause_tab[5] = '{1'b1, 2'b00, 2'b00};
      pause_tab[6] = '{1'b1, 2'b11, 2'b11};
      pause_tab[7] = '{1'b1, 2'b00, 2'b11};

      en_a = 1'b1;
      @(negedge clk);
      chk_on = 1'b1;
      check("reset_ticks", ticks_a, 2'b00);
      check("reset_squares", squares_a, 2'b00);
      rst_c = 1'b0;

      rst_a = 1'b0;
      for (int k = 0; k < 12; k++) begin
         en_a = rst_tab[k].en;
         @(negedge clk);
         check("rst_tab_ticks", ticks_a, rst_tab[k].t);
         check("rst_tab_squares", squares_a, rst_tab[k].s);
      end

      load_a({8'd3, 8'd5});
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         req = {1'(k % 3 == 0), 1'(k % 5 == 0)};
         check("load35_ticks", ticks_a, req);
      end

      load_a({8'd1, 8'd0});
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("div01_ticks", ticks_a, 2'b11);
         check("div01_squares", squares_a, (k % 2 == 1) ? 2'b11 : 2'b00);
      end

      load_a({8'd4, 8'd4});
      for (int k = 0; k < 8; k++) begin
         en_a = pause_tab[k].en;
         @(negedge clk);
         check("pause_ticks", ticks_a, pause_tab[k].t);
         check("pause_squares", squares_a, pause_tab[k].s);
      end

      // Reset landing on the wrap edge: no tick, full period before the next one.
      load_a({8'd4, 8'd4});
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      check("rst_on_wrap_t", ticks_a, 2'b00);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("rst_on_wrap_period", ticks_a, (k == 4) ? 2'b11 : 2'b00);
      end

      repeat (3) @(negedge clk);
      ld_a = 1'b1; div_a = {8'd4, 8'd4};
      @(negedge clk); ld_a = 1'b0;
      check("ld_on_wrap_t", ticks_a, 2'b00);
      check("ld_on_wrap_s", squares_a, 2'b00);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("ld_on_wrap_period", ticks_a, (k == 4) ? 2'b11 : 2'b00);
      end

      rst_a = 1'b1; ld_a = 1'b1; div_a = {8'd2, 8'd2};
      @(negedge clk); rst_a = 1'b0; ld_a = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("rst_beats_load", ticks_a, (k == 4) ? 2'b11 : 2'b00);
      end

      en_c = 1'b1;
      load_c({4'd2, 4'd3});
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         req = {1'(k % 6 == 0), 1'(k % 3 == 0)};
         check("cascade_ticks", ticks_c, req);
      end

      load_c({4'd2, 4'd15});
      tick_cnt = 0;
      for (int k = 1; k <= 1500; k++) begin
         @(negedge clk);
         if (ticks_c[0]) tick_cnt++;
         check("maxw_tick", {1'b0, ticks_c[0]}, {1'b0, 1'(k % 15 == 0)});
      end
      check_int("maxw_periods", tick_cnt, 100);

      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         en_a  = $urandom_range(0, 9) != 0;
         ld_a  = $urandom_range(0, 39) == 0;
         rst_a = $urandom_range(0, 199) == 0;
         div_a = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
         en_c  = $urandom_range(0, 9) != 0;
         ld_c  = $urandom_range(0, 49) == 0;
         rst_c = $urandom_range(0, 299) == 0;
         div_c = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
      end
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
